sliced_cla_adder: RTL and testbench

SLICED_CLA_ADDER -- requirements
Module: sliced_cla_adder

---
 rtl/sliced_cla_adder.sv | 152 +++++++++++++++
 tb/tb_sliced_cla_adder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sliced_cla_adder.sv
// Multi-cycle adder/subtractor: one 8-bit carry-lookahead slice is reused
// NSLICE times to build a W = 8*NSLICE bit result, with a valid/ready
// handshake on both the request and the result side.
module sliced_cla_adder #(
   parameter int unsigned NSLICE = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NSLICE-1:0]   a,
   input  logic [8*NSLICE-1:0]   b,
   input  logic                  cin,
   input  logic                  op_sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NSLICE-1:0]   sum,
   output logic                  cout,
   output logic                  ovf,
   output logic                  zero
);

   localparam int unsigned W    = 8 * NSLICE;
   localparam int unsigned IdxW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [W-1:0]      a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic              carry_q, carry_d;
   logic              cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
   logic [IdxW-1:0]   idx_q, idx_d;

   logic [7:0]        slice_x, slice_y, slice_s;
   logic              slice_c;
   logic [7:0]        gen, prop;
   logic [8:0]        carry_vec;
   logic              la_term, la_prop;

   // Pick the operand slice addressed by the current slice index
   always_comb begin
      slice_x = '0;
      slice_y = '0;
      for (int unsigned s = 0; s < NSLICE; s++) begin
         if (idx_q == IdxW'(s)) begin
            slice_x = a_q[8*s +: 8];
            slice_y = b_q[8*s +: 8];
         end
      end
   end

   // 8-bit carry lookahead: every carry is a flat sum of generate/propagate
   // products back to the slice carry-in, rather than a ripple chain
   always_comb begin
      gen       = slice_x & slice_y;
      prop      = slice_x ^ slice_y;
      carry_vec = '0;
      carry_vec[0] = carry_q;
      la_term   = 1'b0;
      la_prop   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         la_term = gen[i];
         la_prop = prop[i];
         for (int j = i - 1; j >= 0; j--) begin
            la_term = la_term | (la_prop & gen[j]);
            la_prop = la_prop & prop[j];
         end
         carry_vec[i+1] = la_term | (la_prop & carry_q);
      end
      slice_s = prop ^ carry_vec[7:0];
      slice_c = carry_vec[8];
   end

   // Next-state and datapath update for the IDLE/RUN/DONE sequencer
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = op_sub ? ~b : b;
               // Subtract is a + ~b + 1; cin is deliberately ignored
               carry_d = op_sub ? 1'b1 : cin;
               idx_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            for (int unsigned s = 0; s < NSLICE; s++) begin
               if (idx_q == IdxW'(s)) begin
                  sum_d[8*s +: 8] = slice_s;
               end
            end
            carry_d = slice_c;
            idx_d   = idx_q + IdxW'(1);
            if (idx_q == IdxW'(NSLICE - 1)) begin
               state_d = StDone;
               cout_d  = slice_c;
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum_d[W-1] != a_q[W-1]);
               zero_d  = (sum_d == '0);
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset drops any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         idx_q   <= idx_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_sliced_cla_adder.sv
// Directed bench for sliced_cla_adder with the default 4 slices (W = 32).
module tb_sliced_cla_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        cin = 1'b0;
   logic        op_sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;
   logic        zero;

   int n_cmp = 0;
   int n_bad = 0;

   sliced_cla_adder #(.NSLICE(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request, wait for the result and check it; optionally retire it
   task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic vcin, input logic vsub, input logic [31:0] es,
                         input logic ec, input logic eo, input logic ez, input bit retire);
      int cycles;
      @(negedge clk);
      a = va; b = vb; cin = vcin; op_sub = vsub; in_valid = 1'b1;
      check({tag, ".in_ready"}, in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Scramble operands: the captured copy must be used
      a = ~va; b = ~vb; cin = ~vcin; op_sub = ~vsub;
      cycles = 0;
      while (!out_valid && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      check({tag, ".latency"}, cycles, 4);
      check({tag, ".sum"}, sum, es);
      check({tag, ".cout"}, cout, ec);
      check({tag, ".ovf"}, ovf, eo);
      check({tag, ".zero"}, zero, ez);
      if (retire) begin
         @(negedge clk);
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         check({tag, ".retired"}, out_valid, 0);
      end
   endtask

   initial begin
      // Reset state
      #1 rst = 1'b1;
      #2;
      check("rst.in_ready", in_ready, 1);
      check("rst.out_valid", out_valid, 0);
      check("rst.sum", sum, 32'h0);
      check("rst.flags", {cout, ovf, zero}, 3'b000);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_op("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
             32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
      run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0,
             32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
      run_op("sub_5_7", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1,
             32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op("sub_min_1", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1,
             32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);

      // Backpressure: result held for 10 cycles while new requests are offered
      run_op("bp_first", 32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0,
             32'h0000_1235, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         a = $urandom; b = $urandom; cin = i[0]; op_sub = i[1];
         @(posedge clk);
         #1;
         check("bp.sum", sum, 32'h0000_1235);
         check("bp.flags", {cout, ovf, zero}, 3'b000);
         check("bp.in_ready", in_ready, 0);
         check("bp.out_valid", out_valid, 1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      a = 32'h0001_0000; b = 32'h0000_FFFF; cin = 1'b0; op_sub = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp.release_ready", in_ready, 1);
      check("bp.release_valid", out_valid, 0);
      run_op("bp_next", 32'h0001_0000, 32'h0000_FFFF, 1'b0, 1'b0,
             32'h0001_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset while slice 2 is in progress
      @(negedge clk);
      a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid.in_ready", in_ready, 1);
      check("rst_mid.out_valid", out_valid, 0);
      check("rst_mid.sum", sum, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid.no_valid", out_valid, 0);
      run_op("rst_mid.redo", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
             32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
